arm_ldm_sequencer: RTL and testbench

Parametrised micro-op sequencer for ARM block transfers (LDM/STM), replacing the fixed 2-bit micro-instruction counter in the combined decoder.
- Sits in the Decode stage, beside the combined ARM/RISC-V decoder.
- Accepts one decoded block-transfer instruction.
- Expands its register list into one load/store micro-op per listed register, followed by an optional base-writeback micro-op.
- Supports all four addressing modes, with a valid/ready handshake toward the Execute stage.
- Holds Fetch stalled while a sequence is in progress.

---
 rtl/arm_ldm_sequencer_pkg.sv | 8 +
 rtl/arm_ldm_sequencer_if.sv | 25 ++
 rtl/arm_ldm_sequencer_prio_enc.sv | 20 ++
 rtl/arm_ldm_sequencer.sv | 109 ++++++++++
 tb/tb_arm_ldm_sequencer.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/arm_ldm_sequencer_pkg.sv
// arm_ldmseq_pkg: shared types and start-offset helper for the LDM/STM micro-op sequencer
package arm_ldmseq_pkg;
  typedef enum logic [1:0] {IDLE, XFER, WB} state_e;
  typedef enum logic [1:0] {DA = 2'b00, IA = 2'b01, DB = 2'b10, IB = 2'b11} mode_e;
  function automatic int start_off(mode_e m, int n);
    return m == IA ? 0 : m == IB ? 4 : m == DA ? 4 - 4 * n : -4 * n;
  endfunction
endpackage

// File: rtl/arm_ldm_sequencer_if.sv
// arm_ldm_sequencer_if: micro-op valid/ready bundle from the sequencer to Execute
interface arm_ldm_sequencer_if #(
  parameter int NREGS  = 16,
  parameter int RIDX_W = $clog2(NREGS),
  parameter int OFF_W  = RIDX_W + 4
);
  logic              uop_valid;
  logic              uop_ready;
  logic [RIDX_W-1:0] uop_rd;
  logic [OFF_W-1:0]  uop_offset;
  logic              uop_load;
  logic              uop_store;
  logic              uop_wb;
  logic              uop_first;
  logic              uop_last;
  logic              uop_pcload;
  modport master (
    output uop_valid, uop_rd, uop_offset, uop_load, uop_store, uop_wb, uop_first, uop_last, uop_pcload,
    input  uop_ready
  );
  modport slave (
    input  uop_valid, uop_rd, uop_offset, uop_load, uop_store, uop_wb, uop_first, uop_last, uop_pcload,
    output uop_ready
  );
endinterface

// File: rtl/arm_ldm_sequencer_prio_enc.sv
// arm_ldmseq_prio_enc: lowest-set-bit index, single-bit flag and popcount of a register list
module arm_ldmseq_prio_enc #(
  parameter int NREGS  = 16,
  parameter int RIDX_W = $clog2(NREGS)
) (
  input  logic [NREGS-1:0] list,
  output logic [RIDX_W-1:0] idx,
  output logic              one,
  output logic [RIDX_W:0]   cnt
);
  always_comb begin
    idx = '0;
    cnt = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (list[i]) idx = RIDX_W'(i);
      cnt = cnt + (RIDX_W + 1)'(list[i]);
    end
  end
  assign one = cnt == (RIDX_W + 1)'(1);
endmodule

// File: rtl/arm_ldm_sequencer.sv
// arm_ldm_sequencer: expands an LDM/STM register list into load/store micro-ops plus optional base writeback.
// Define ARM_LDMSEQ_PERF_EN to add saturating sequence/micro-op performance counters.
module arm_ldm_sequencer
  import arm_ldmseq_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int RIDX_W = $clog2(NREGS),
  parameter int OFF_W  = RIDX_W + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NREGS-1:0]  reglist,
  input  logic [RIDX_W-1:0] rn,
  input  logic              p,
  input  logic              u,
  input  logic              w,
  input  logic              l,
  input  logic              flush,
  output logic              busy,
  output logic              stall_f,
  arm_ldm_sequencer_if.master uop
`ifdef ARM_LDMSEQ_PERF_EN
  ,
  output logic [31:0]       perf_seq_cnt,
  output logic [31:0]       perf_uop_cnt
`endif
);
  state_e            state;
  logic [NREGS-1:0]  list;
  logic [RIDX_W-1:0] rn_q, idx;
  logic [RIDX_W:0]   n_q, cnt;
  logic [OFF_W-1:0]  off, mag;
  logic              l_q, u_q, wb_q, first, one, accept, xfer, hs;
  // One encoder serves both: popcount of the incoming list while idle, lowest bit of the remaining list otherwise
  arm_ldmseq_prio_enc #(.NREGS(NREGS)) u_enc (
    .list(state == IDLE ? reglist : list),
    .idx (idx),
    .one (one),
    .cnt (cnt)
  );
  assign xfer   = state == XFER;
  assign accept = state == IDLE && start && !flush && cnt != '0;
  assign hs     = uop.uop_valid && uop.uop_ready;
  assign mag    = OFF_W'({n_q, 2'b00});
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      list  <= '0;
      rn_q  <= '0;
      n_q   <= '0;
      off   <= '0;
      l_q   <= 1'b0;
      u_q   <= 1'b0;
      wb_q  <= 1'b0;
      first <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      list  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= XFER;
          list  <= reglist;
          rn_q  <= rn;
          n_q   <= cnt;
          l_q   <= l;
          u_q   <= u;
          wb_q  <= w && !(l && reglist[rn]);
          off   <= OFF_W'(start_off(mode_e'({p, u}), int'(cnt)));
          first <= 1'b1;
        end
        XFER: if (uop.uop_ready) begin
          list  <= list & ~(NREGS'(1) << idx);
          off   <= off + OFF_W'(4);
          first <= 1'b0;
          if (one) state <= wb_q ? WB : IDLE;
        end
        WB: if (uop.uop_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy           = state != IDLE;
  assign uop.uop_valid  = busy;
  assign uop.uop_rd     = state == WB ? rn_q : xfer ? idx : '0;
  assign uop.uop_offset = state == WB ? (u_q ? mag : -mag) : xfer ? off : '0;
  assign uop.uop_load   = xfer && l_q;
  assign uop.uop_store  = xfer && !l_q;
  assign uop.uop_wb     = state == WB;
  assign uop.uop_first  = busy && first;
  assign uop.uop_last   = state == WB || (xfer && one && !wb_q);
  assign uop.uop_pcload = xfer && l_q && idx == RIDX_W'(NREGS - 1);
  assign stall_f        = accept || (busy && !(uop.uop_last && uop.uop_ready));
`ifdef ARM_LDMSEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_seq_cnt <= '0;
      perf_uop_cnt <= '0;
    end else begin
      if (hs && !flush && !(&perf_uop_cnt)) perf_uop_cnt <= perf_uop_cnt + 32'd1;
      if (hs && !flush && uop.uop_last && !(&perf_seq_cnt)) perf_seq_cnt <= perf_seq_cnt + 32'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif
endmodule

// File: tb/tb_arm_ldm_sequencer.sv
// tb_arm_ldm_sequencer: directed scenarios for the LDM/STM micro-op sequencer
module tb_arm_ldm_sequencer;
  localparam int LD = 32, ST = 16, WBF = 8, FI = 4, LA = 2, PC = 1;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] reglist = '0;
  logic [3:0]  rn = '0;
  logic        p = 1'b0, u = 1'b0, w = 1'b0, l = 1'b0, flush = 1'b0;
  logic        busy, stall_f;
  logic [20:0] obs;
  int          cmp = 0, bad = 0;
`ifdef ARM_LDMSEQ_PERF_EN
  logic [31:0] perf_seq_cnt, perf_uop_cnt;
`endif
  arm_ldm_sequencer_if #(.NREGS(16)) u_if ();
  arm_ldm_sequencer #(.NREGS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .reglist(reglist), .rn(rn),
    .p(p), .u(u), .w(w), .l(l), .flush(flush),
    .busy(busy), .stall_f(stall_f), .uop(u_if)
`ifdef ARM_LDMSEQ_PERF_EN
    , .perf_seq_cnt(perf_seq_cnt), .perf_uop_cnt(perf_uop_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign obs = {u_if.uop_valid, u_if.uop_rd, u_if.uop_offset, u_if.uop_load, u_if.uop_store, u_if.uop_wb,
                u_if.uop_first, u_if.uop_last, u_if.uop_pcload, stall_f, busy};
  function automatic logic [20:0] e(int v, int rd, int off, int fl, int st, int bs);
    return {1'(v), 4'(rd), 8'(off), 6'(fl), 1'(st), 1'(bs)};
  endfunction
  task automatic instr(logic [15:0] rl, logic [3:0] r, logic pp, logic uu, logic ww, logic ll);
    reglist = rl; rn = r; p = pp; u = uu; w = ww; l = ll;
  endtask
  task automatic test_reset();
    u_if.uop_ready = 1'b1;
    #1;
    cmp++; if (obs !== '0) begin bad++; $display("FAIL reset got %h exp %h", obs, 21'h0); end
    @(negedge clk); rst = 1'b1; #1;
    cmp++; if (obs !== '0) begin bad++; $display("FAIL reset_release got %h exp %h", obs, 21'h0); end
  endtask
  task automatic test_ldmia_wb();
    logic [20:0] x [6];
    x = '{e(0,0,0,0,1,0), e(1,1,0,LD|FI,1,1), e(1,2,4,LD,1,1), e(1,5,8,LD,1,1),
          e(1,0,12,WBF|LA,0,1), e(0,0,0,0,0,0)};
    instr(16'h0026, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); start = k == 0; u_if.uop_ready = 1'b1; #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL ldmia_wb c%0d got %h exp %h", k, obs, x[k]); end
    end
  endtask
  task automatic test_stmdb();
    logic [20:0] x [5];
    x = '{e(0,0,0,0,1,0), e(1,4,-8,ST|FI,1,1), e(1,14,-4,ST,1,1), e(1,13,-8,WBF|LA,0,1), e(0,0,0,0,0,0)};
    instr(16'h4010, 4'd13, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); start = k == 0; u_if.uop_ready = 1'b1; #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL stmdb c%0d got %h exp %h", k, obs, x[k]); end
    end
  endtask
  task automatic test_backpressure();
    logic [20:0] x [8];
    x = '{e(0,0,0,0,1,0), e(1,1,0,LD|FI,1,1), e(1,2,4,LD,1,1), e(1,2,4,LD,1,1), e(1,2,4,LD,1,1),
          e(1,5,8,LD,1,1), e(1,0,12,WBF|LA,0,1), e(0,0,0,0,0,0)};
    instr(16'h0026, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); start = k == 0; u_if.uop_ready = !(k == 2 || k == 3); #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL backpressure c%0d got %h exp %h", k, obs, x[k]); end
    end
    u_if.uop_ready = 1'b1;
  endtask
  task automatic test_pcload();
    logic [20:0] x [3];
    x = '{e(0,0,0,0,1,0), e(1,15,0,LD|FI|LA|PC,0,1), e(0,0,0,0,0,0)};
    instr(16'h8000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); start = k == 0; #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL pcload c%0d got %h exp %h", k, obs, x[k]); end
    end
  endtask
  task automatic test_flush();
    logic [20:0] x [5];
    x = '{e(0,0,0,0,1,0), e(1,1,0,LD|FI,1,1), e(1,2,4,LD,1,1), e(0,0,0,0,0,0), e(0,0,0,0,0,0)};
    instr(16'h0026, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); start = k == 0; flush = k == 2; #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL flush c%0d got %h exp %h", k, obs, x[k]); end
    end
    flush = 1'b0;
  endtask
  task automatic test_reset_mid();
    logic [20:0] x [4];
    x = '{e(0,0,0,0,1,0), e(1,1,0,LD|FI,1,1), e(0,0,0,0,0,0), e(0,0,0,0,0,0)};
    instr(16'h0026, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); start = k == 0; rst = k != 2; #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL reset_mid c%0d got %h exp %h", k, obs, x[k]); end
    end
  endtask
  task automatic test_rn_in_list();
    logic [20:0] x [4];
    x = '{e(0,0,0,0,1,0), e(1,1,0,LD|FI,1,1), e(1,2,4,LD|LA,0,1), e(0,0,0,0,0,0)};
    instr(16'h0006, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); start = k == 0; #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL rn_in_list c%0d got %h exp %h", k, obs, x[k]); end
    end
  endtask
  task automatic test_stmda_busy_start();
    logic [20:0] x [5];
    x = '{e(0,0,0,0,1,0), e(1,0,-4,ST|FI,1,1), e(1,7,0,ST,1,1), e(1,2,-8,WBF|LA,0,1), e(0,0,0,0,0,0)};
    instr(16'h0081, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); start = k < 3; if (k == 1) reglist = 16'hFFFF; #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL stmda_busy c%0d got %h exp %h", k, obs, x[k]); end
    end
  endtask
  task automatic test_ldmib();
    logic [20:0] x [3];
    x = '{e(0,0,0,0,1,0), e(1,3,4,LD|FI|LA,0,1), e(0,0,0,0,0,0)};
    instr(16'h0008, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); start = k == 0; #1;
      cmp++; if (obs !== x[k]) begin bad++; $display("FAIL ldmib c%0d got %h exp %h", k, obs, x[k]); end
    end
  endtask
  task automatic test_empty();
    instr(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); start = k == 0; #1;
      cmp++; if (obs !== '0) begin bad++; $display("FAIL empty c%0d got %h exp %h", k, obs, 21'h0); end
    end
  endtask
  initial begin
    u_if.uop_ready = 1'b1;
    test_reset();
    test_ldmia_wb();
    test_stmdb();
    test_backpressure();
    test_pcload();
    test_flush();
    test_reset_mid();
    test_rn_in_list();
    test_stmda_busy_start();
    test_ldmib();
    test_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
